// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encodings, input port indices,
// default flit width and output-arbiter FSM states.
package noc_pkg;

  localparam int FLIT_W_DEF = 8;

  localparam int PORT_L = 0;
  localparam int PORT_E = 1;
  localparam int PORT_W = 2;
  localparam int PORT_S = 3;
  localparam int PORT_N = 4;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_TAIL   = 2'b01,
    FT_HDR    = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // A flit may open a new packet when it is a header or a single-flit packet.
  function automatic logic starts_packet(input logic [1:0] ftype);
    return (ftype == FT_HDR) || (ftype == FT_SINGLE);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority selector: returns the first request at or after ptr,
// wrapping from N-1 back to 0, as both a one-hot vector and an index.
module rr_arbiter #(
  parameter int N     = 5,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan the N positions starting at ptr and keep only the first hit.
  always_comb begin
    int p;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    p     = 0;
    for (int k = 0; k < N; k++) begin
      p = int'(ptr) + k;
      if (p >= N) p = p - N;
      if (!valid && req[p]) begin
        valid  = 1'b1;
        gnt[p] = 1'b1;
        idx    = IDX_W'(p);
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Output port arbiter for a wormhole NoC router. Grants whole packets:
// a header locks the output to its input until the tail passes, single-flit
// packets are granted without locking. The granted flit is registered into
// a one-deep output stage that sustains one flit per cycle.
// Optional feature: define ARB_LOCK_TIMEOUT_EN to release a lock after
// LOCK_TIMEOUT consecutive idle cycles (lock_timeout pulses when it fires).
module output_port_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_PORTS    = 5,
  parameter int FLIT_W       = FLIT_W_DEF,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS*FLIT_W-1:0] flit_in,
  output logic [NUM_PORTS-1:0]        grant,
  output logic [FLIT_W-1:0]           flit_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        orphan_err,
  output logic                        lock_timeout
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  arb_state_e         state, state_nx;
  logic [IDX_W-1:0]   owner, owner_nx;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nx;

  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] orphan_cand;
  logic [NUM_PORTS-1:0] win_onehot;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_valid;

  logic [FLIT_W-1:0] win_flit;
  logic [FLIT_W-1:0] owner_flit;
  logic [FLIT_W-1:0] sel_flit;
  logic              do_grant;
  logic              acc;
  logic              tmo;

`ifdef ARB_LOCK_TIMEOUT_EN
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  logic [CNT_W-1:0] idle_cnt, idle_cnt_nx;
`endif

  // Split requests into packet openers and stray body/tail flits.
  always_comb begin
    eligible    = '0;
    orphan_cand = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (starts_packet(flit_in[i*FLIT_W + FLIT_W - 2 +: 2]))
        eligible[i] = req[i];
      else
        orphan_cand[i] = req[i];
    end
  end

  rr_arbiter #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_rr (
    .req   (eligible),
    .ptr   (rr_ptr),
    .gnt   (win_onehot),
    .idx   (win_idx),
    .valid (win_valid)
  );

  assign acc        = !out_valid || out_ready;
  assign win_flit   = flit_in[win_idx*FLIT_W +: FLIT_W];
  assign owner_flit = flit_in[owner*FLIT_W +: FLIT_W];

  // Next-state, grant and error decisions; all pulses forced low in reset.
  always_comb begin
    state_nx  = state;
    owner_nx  = owner;
    rr_ptr_nx = rr_ptr;
    grant     = '0;
    sel_flit  = '0;
    do_grant  = 1'b0;
    orphan_err = 1'b0;
    tmo       = 1'b0;
`ifdef ARB_LOCK_TIMEOUT_EN
    idle_cnt_nx = idle_cnt;
`endif
    case (state)
      ST_IDLE: begin
`ifdef ARB_LOCK_TIMEOUT_EN
        idle_cnt_nx = '0;
`endif
        if (win_valid && acc) begin
          grant    = win_onehot;
          do_grant = 1'b1;
          sel_flit = win_flit;
          if (win_idx == IDX_W'(NUM_PORTS - 1))
            rr_ptr_nx = '0;
          else
            rr_ptr_nx = win_idx + 1'b1;
          if (win_flit[FLIT_W-1 -: 2] == FT_HDR) begin
            state_nx = ST_LOCKED;
            owner_nx = win_idx;
          end
        end else if (!win_valid && (|orphan_cand)) begin
          orphan_err = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (req[owner] && acc) begin
          grant[owner] = 1'b1;
          do_grant     = 1'b1;
          sel_flit     = owner_flit;
          if (owner_flit[FLIT_W-1 -: 2] == FT_TAIL)
            state_nx = ST_IDLE;
`ifdef ARB_LOCK_TIMEOUT_EN
          idle_cnt_nx = '0;
        end else if (idle_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          tmo         = 1'b1;
          state_nx    = ST_IDLE;
          idle_cnt_nx = '0;
        end else begin
          idle_cnt_nx = idle_cnt + 1'b1;
`endif
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    if (!reset_n) begin
      grant      = '0;
      do_grant   = 1'b0;
      orphan_err = 1'b0;
      tmo        = 1'b0;
    end
  end

`ifdef ARB_LOCK_TIMEOUT_EN
  assign lock_timeout = tmo;
`else
  assign lock_timeout = 1'b0;
`endif

  // Arbitration state: FSM, lock owner, round-robin pointer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      owner  <= IDX_W'(PORT_L);
      rr_ptr <= '0;
    end else begin
      state  <= state_nx;
      owner  <= owner_nx;
      rr_ptr <= rr_ptr_nx;
    end
  end

`ifdef ARB_LOCK_TIMEOUT_EN
  // Idle-cycle counter that bounds how long a silent owner may hold the lock.
  always_ff @(posedge clk) begin
    if (!reset_n) idle_cnt <= '0;
    else          idle_cnt <= idle_cnt_nx;
  end
`endif

  // One-deep output stage: load on grant, drain when downstream accepts.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flit_out  <= '0;
      out_valid <= 1'b0;
    end else if (do_grant) begin
      flit_out  <= sel_flit;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // tmo is only consumed when the timeout feature is built in.
  logic unused_tmo;
  assign unused_tmo = tmo ^ (LOCK_TIMEOUT < 0);

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed self-checking bench for output_port_arbiter (5 ports, 8-bit flits).
module tb_output_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  req;
  logic [39:0] flit_in;
  logic [4:0]  grant;
  logic [7:0]  flit_out;
  logic        out_valid;
  logic        out_ready;
  logic        orphan_err;
  logic        lock_timeout;

  int n_assert = 0;
  int n_fail   = 0;

  output_port_arbiter #(
    .NUM_PORTS    (5),
    .FLIT_W       (8),
    .LOCK_TIMEOUT (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .flit_in      (flit_in),
    .grant        (grant),
    .flit_out     (flit_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .orphan_err   (orphan_err),
    .lock_timeout (lock_timeout)
  );

  // 10 ns clock; inputs change on the falling edge
  always #5 clk = ~clk;

  // One immediate-assertion comparison point
  task automatic checkOutput(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, reset released
  task automatic applyStimulus(input logic [4:0] r, input logic [39:0] f, input logic rdy);
    @(negedge clk);
    reset_n   = 1'b1;
    req       = r;
    flit_in   = f;
    out_ready = rdy;
  endtask

  // Combinational outputs, checked 1 ns after inputs settle
  task automatic checkComb(input string tag, input logic [4:0] g, input logic orph);
    #1;
    checkOutput({tag, ".grant"}, 40'(grant), 40'(g));
    checkOutput({tag, ".orphan"}, 40'(orphan_err), 40'(orph));
    checkOutput({tag, ".tmo"}, 40'(lock_timeout), 40'(1'b0));
  endtask

  // Registered outputs, checked 1 ns after the rising edge
  task automatic checkReg(input string tag, input logic [7:0] f, input logic v);
    @(posedge clk);
    #1;
    checkOutput({tag, ".flit_out"}, 40'(flit_out), 40'(f));
    checkOutput({tag, ".out_valid"}, 40'(out_valid), 40'(v));
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_n   = 1'b0;
    req       = '0;
    flit_in   = '0;
    out_ready = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    // Reset: requests present but everything gated off
    reset_n   = 1'b0;
    out_ready = 1'b1;
    req       = 5'b11111;
    flit_in   = {8'h85, 8'h01, 8'h85, 8'h85, 8'h85};
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst.grant", 40'(grant), 40'h0);
    checkOutput("rst.orphan", 40'(orphan_err), 40'h0);
    checkOutput("rst.tmo", 40'(lock_timeout), 40'h0);
    checkOutput("rst.flit_out", 40'(flit_out), 40'h0);
    checkOutput("rst.out_valid", 40'(out_valid), 40'h0);

    // Header from port 0 locks the output
    doReset();
    applyStimulus(5'b00001, {8'h00, 8'h00, 8'h00, 8'h00, 8'h85}, 1'b1);
    checkComb("hdr0", 5'b00001, 1'b0);
    checkReg("hdr0", 8'h85, 1'b1);
    applyStimulus(5'b00010, {8'h00, 8'h00, 8'h00, 8'h8A, 8'h00}, 1'b1);
    checkComb("lock0", 5'b00000, 1'b0);
    checkReg("lock0", 8'h85, 1'b0);
    applyStimulus(5'b00011, {8'h00, 8'h00, 8'h00, 8'h8A, 8'h45}, 1'b1);
    checkComb("tail0", 5'b00001, 1'b0);
    checkReg("tail0", 8'h45, 1'b1);
    applyStimulus(5'b00010, {8'h00, 8'h00, 8'h00, 8'hC5, 8'h00}, 1'b1);
    checkComb("single1", 5'b00010, 1'b0);
    checkReg("single1", 8'hC5, 1'b1);

    // Round robin over single-flit packets at full throughput
    doReset();
    applyStimulus(5'b10101, {8'hC4, 8'h00, 8'hC2, 8'h00, 8'hC0}, 1'b1);
    checkComb("rr1", 5'b00001, 1'b0);
    checkReg("rr1", 8'hC0, 1'b1);
    applyStimulus(5'b10101, {8'hC4, 8'h00, 8'hC2, 8'h00, 8'hC0}, 1'b1);
    checkComb("rr2", 5'b00100, 1'b0);
    checkReg("rr2", 8'hC2, 1'b1);
    applyStimulus(5'b10101, {8'hC4, 8'h00, 8'hC2, 8'h00, 8'hC0}, 1'b1);
    checkComb("rr3", 5'b10000, 1'b0);
    checkReg("rr3", 8'hC4, 1'b1);
    applyStimulus(5'b10101, {8'hC4, 8'h00, 8'hC2, 8'h00, 8'hC0}, 1'b1);
    checkComb("rr4", 5'b00001, 1'b0);
    checkReg("rr4", 8'hC0, 1'b1);

    // Port 2 holds the lock until its tail; port 4 waits
    doReset();
    applyStimulus(5'b00100, {8'h00, 8'h00, 8'h85, 8'h00, 8'h00}, 1'b1);
    checkComb("p2hdr", 5'b00100, 1'b0);
    checkReg("p2hdr", 8'h85, 1'b1);
    applyStimulus(5'b10100, {8'h8A, 8'h00, 8'h05, 8'h00, 8'h00}, 1'b1);
    checkComb("p2body", 5'b00100, 1'b0);
    checkReg("p2body", 8'h05, 1'b1);
    applyStimulus(5'b10100, {8'h8A, 8'h00, 8'h86, 8'h00, 8'h00}, 1'b1);
    checkComb("p2hdrbody", 5'b00100, 1'b0);
    checkReg("p2hdrbody", 8'h86, 1'b1);
    applyStimulus(5'b10100, {8'h8A, 8'h00, 8'h45, 8'h00, 8'h00}, 1'b1);
    checkComb("p2tail", 5'b00100, 1'b0);
    checkReg("p2tail", 8'h45, 1'b1);
    applyStimulus(5'b10000, {8'h8A, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1);
    checkComb("p4hdr", 5'b10000, 1'b0);
    checkReg("p4hdr", 8'h8A, 1'b1);

    // Backpressure: no grant while the output stage is full and stalled
    doReset();
    applyStimulus(5'b00001, {8'h00, 8'h00, 8'h00, 8'h00, 8'hC1}, 1'b0);
    checkComb("bp.load", 5'b00001, 1'b0);
    checkReg("bp.load", 8'hC1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5'b00001, {8'h00, 8'h00, 8'h00, 8'h00, 8'hC3}, 1'b0);
      checkComb("bp.stall", 5'b00000, 1'b0);
      checkReg("bp.stall", 8'hC1, 1'b1);
    end
    applyStimulus(5'b00001, {8'h00, 8'h00, 8'h00, 8'h00, 8'hC3}, 1'b1);
    checkComb("bp.release", 5'b00001, 1'b0);
    checkReg("bp.release", 8'hC3, 1'b1);
    applyStimulus(5'b00000, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1);
    checkComb("bp.drain", 5'b00000, 1'b0);
    checkReg("bp.drain", 8'hC3, 1'b0);

    // Orphan body flit with nothing eligible
    doReset();
    applyStimulus(5'b01000, {8'h00, 8'h01, 8'h00, 8'h00, 8'h00}, 1'b1);
    checkComb("orphan", 5'b00000, 1'b1);
    checkReg("orphan", 8'h00, 1'b0);
    applyStimulus(5'b00000, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1);
    checkComb("orphan.clr", 5'b00000, 1'b0);
    applyStimulus(5'b01001, {8'h00, 8'h01, 8'h00, 8'h00, 8'hC2}, 1'b1);
    checkComb("orphan.masked", 5'b00001, 1'b0);
    checkReg("orphan.masked", 8'hC2, 1'b1);

    // Reset in the middle of a packet drops the lock
    doReset();
    applyStimulus(5'b00010, {8'h00, 8'h00, 8'h00, 8'h85, 8'h00}, 1'b1);
    checkComb("mid.hdr", 5'b00010, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    req     = 5'b00010;
    flit_in = {8'h00, 8'h00, 8'h00, 8'h05, 8'h00};
    #1;
    checkOutput("mid.rst.grant", 40'(grant), 40'h0);
    @(posedge clk);
    #1;
    checkOutput("mid.rst.valid", 40'(out_valid), 40'h0);
    checkOutput("mid.rst.flit", 40'(flit_out), 40'h0);
    applyStimulus(5'b01000, {8'h00, 8'h8B, 8'h00, 8'h00, 8'h00}, 1'b1);
    checkComb("mid.after", 5'b01000, 1'b0);
    checkReg("mid.after", 8'h8B, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
